// File: rtl/mem_sched_pkg.sv
// Shared direction/state types and default geometry for the Cell RAM burst scheduler.
package mem_sched_pkg;

  localparam int unsigned DefBurstWords = 16;
  localparam int unsigned DefRegionAw   = 20;

  typedef enum logic {
    DirWrite = 1'b0,
    DirRead  = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StUpdate
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first set request at or after ptr_i, wrapping at N-1.
module rr_pick #(
  parameter int unsigned N    = 16,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned s;
      s = 32'(ptr_i) + i;
      if (s >= N) s = s - N;
      if (!valid_o && req_i[IdxW'(s)]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(s);
      end
    end
  end

endmodule

// File: rtl/mem_burst_scheduler.sv
// Cell RAM burst scheduler: picks one write/read slot per port, one burst in flight at a time.
// Define MEM_SCHED_READ_PRIORITY_EN to serve any eligible read slot ahead of all write slots.
module mem_burst_scheduler
  import mem_sched_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 8,
  parameter int unsigned FIFO_AW     = 11,
  parameter int unsigned REGION_AW   = DefRegionAw,
  parameter int unsigned BURST_WORDS = DefBurstWords
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0]               port_enable,
  input  logic [NUM_PORTS*(FIFO_AW+1)-1:0]   wr_fifo_level,
  input  logic [NUM_PORTS*(FIFO_AW+1)-1:0]   rd_fifo_space,
  output logic                               req_valid,
  input  logic                               req_ready,
  output logic                               req_dir,
  output logic [2:0]                         req_port,
  output logic [22:0]                        req_addr,
  output logic [$clog2(BURST_WORDS):0]       req_len,
  input  logic                               req_done,
  output logic [NUM_PORTS*(REGION_AW+1)-1:0] ram_count,
  output logic                               busy,
  output logic                               protocol_err
);

  localparam int unsigned NumSlots = 2 * NUM_PORTS;
  localparam int unsigned SlotW    = $clog2(NumSlots);
  localparam int unsigned LevelW   = FIFO_AW + 1;
  localparam int unsigned CountW   = REGION_AW + 1;
  localparam int unsigned LenW     = $clog2(BURST_WORDS) + 1;

  localparam logic [LevelW-1:0]    BurstBytes = LevelW'(2 * BURST_WORDS);
  localparam logic [CountW-1:0]    BurstCnt   = CountW'(BURST_WORDS);
  localparam logic [CountW-1:0]    WrMaxCnt   = CountW'((1 << REGION_AW) - BURST_WORDS);
  localparam logic [REGION_AW-1:0] BurstPtr   = REGION_AW'(BURST_WORDS);

  state_e                state_q, state_d;
  logic [SlotW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SlotW-1:0]      gnt_q, gnt_d;
  logic                  req_valid_q, req_valid_d;
  logic                  req_dir_q, req_dir_d;
  logic [2:0]            req_port_q, req_port_d;
  logic [22:0]           req_addr_q, req_addr_d;
  logic [LenW-1:0]       req_len_q, req_len_d;
  logic                  protocol_err_q, protocol_err_d;
  logic [REGION_AW-1:0]  wr_ptr_q [NUM_PORTS];
  logic [REGION_AW-1:0]  wr_ptr_d [NUM_PORTS];
  logic [REGION_AW-1:0]  rd_ptr_q [NUM_PORTS];
  logic [REGION_AW-1:0]  rd_ptr_d [NUM_PORTS];
  logic [CountW-1:0]     count_q  [NUM_PORTS];
  logic [CountW-1:0]     count_d  [NUM_PORTS];

  logic [NumSlots-1:0]   elig;
  logic                  pick_valid;
  logic [SlotW-1:0]      pick_idx;
  logic [2:0]            pick_port;
  logic [REGION_AW-1:0]  pick_ptr;
  logic [2:0]            gnt_port;

  // Slot 2*p is port p's write side, slot 2*p+1 its read side.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [LevelW-1:0] wr_level;
    logic [LevelW-1:0] rd_space;
    assign wr_level = wr_fifo_level[p*LevelW +: LevelW];
    assign rd_space = rd_fifo_space[p*LevelW +: LevelW];
    assign elig[2*p]   = port_enable[p] && (wr_level >= BurstBytes) && (count_q[p] <= WrMaxCnt);
    assign elig[2*p+1] = port_enable[p] && (count_q[p] >= BurstCnt) && (rd_space >= BurstBytes);
    assign ram_count[p*CountW +: CountW] = count_q[p];
  end

`ifdef MEM_SCHED_READ_PRIORITY_EN
  logic [NumSlots-1:0] elig_rd, elig_wr;
  logic                rd_valid, wr_valid;
  logic [SlotW-1:0]    rd_idx, wr_idx;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_split
    assign elig_wr[2*p]   = elig[2*p];
    assign elig_wr[2*p+1] = 1'b0;
    assign elig_rd[2*p]   = 1'b0;
    assign elig_rd[2*p+1] = elig[2*p+1];
  end

  rr_pick #(.N(NumSlots)) u_pick_rd (
    .req_i   (elig_rd),
    .ptr_i   (rr_ptr_q),
    .valid_o (rd_valid),
    .idx_o   (rd_idx)
  );

  rr_pick #(.N(NumSlots)) u_pick_wr (
    .req_i   (elig_wr),
    .ptr_i   (rr_ptr_q),
    .valid_o (wr_valid),
    .idx_o   (wr_idx)
  );

  assign pick_valid = rd_valid | wr_valid;
  assign pick_idx   = rd_valid ? rd_idx : wr_idx;
`else
  rr_pick #(.N(NumSlots)) u_pick (
    .req_i   (elig),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );
`endif

  assign pick_port = 3'(pick_idx >> 1);
  assign pick_ptr  = pick_idx[0] ? rd_ptr_q[pick_port] : wr_ptr_q[pick_port];
  assign gnt_port  = 3'(gnt_q >> 1);

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    gnt_d          = gnt_q;
    req_valid_d    = req_valid_q;
    req_dir_d      = req_dir_q;
    req_port_d     = req_port_q;
    req_addr_d     = req_addr_q;
    req_len_d      = req_len_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    protocol_err_d = protocol_err_q | (req_done && (state_q != StWait));

    unique case (state_q)
      StIdle: begin
        // A port disabled while idle is flushed so it restarts from an empty region.
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (!port_enable[p]) begin
            wr_ptr_d[p] = '0;
            rd_ptr_d[p] = '0;
            count_d[p]  = '0;
          end
        end
        if (pick_valid) begin
          gnt_d       = pick_idx;
          req_valid_d = 1'b1;
          req_dir_d   = pick_idx[0];
          req_port_d  = pick_port;
          req_addr_d  = 23'({pick_port, pick_ptr});
          req_len_d   = LenW'(BURST_WORDS);
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (req_done) state_d = StUpdate;
      end
      StUpdate: begin
        if (gnt_q[0] == DirRead) begin
          rd_ptr_d[gnt_port] = rd_ptr_q[gnt_port] + BurstPtr;
          count_d[gnt_port]  = count_q[gnt_port] - BurstCnt;
        end else begin
          wr_ptr_d[gnt_port] = wr_ptr_q[gnt_port] + BurstPtr;
          count_d[gnt_port]  = count_q[gnt_port] + BurstCnt;
        end
        rr_ptr_d = (gnt_q == SlotW'(NumSlots - 1)) ? '0 : gnt_q + 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      rr_ptr_q       <= '0;
      gnt_q          <= '0;
      req_valid_q    <= 1'b0;
      req_dir_q      <= 1'b0;
      req_port_q     <= '0;
      req_addr_q     <= '0;
      req_len_q      <= '0;
      protocol_err_q <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        count_q[p]  <= '0;
      end
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      gnt_q          <= gnt_d;
      req_valid_q    <= req_valid_d;
      req_dir_q      <= req_dir_d;
      req_port_q     <= req_port_d;
      req_addr_q     <= req_addr_d;
      req_len_q      <= req_len_d;
      protocol_err_q <= protocol_err_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  assign req_valid    = req_valid_q;
  assign req_dir      = req_dir_q;
  assign req_port     = req_port_q;
  assign req_addr     = req_addr_q;
  assign req_len      = req_len_q;
  assign protocol_err = protocol_err_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_mem_burst_scheduler.sv
// Directed bench for mem_burst_scheduler: a default-geometry instance plus a 64-word-region one.
module tb_mem_burst_scheduler;

  localparam int unsigned NP  = 8;
  localparam int unsigned LW  = 12;
  localparam int unsigned CW  = 21;
  localparam int unsigned SCW = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP-1:0]    port_enable;
  logic [NP*LW-1:0] wr_fifo_level, rd_fifo_space;
  logic             req_ready, req_done, s_req_ready, s_req_done;

  logic             req_valid, req_dir, busy, protocol_err;
  logic [2:0]       req_port;
  logic [22:0]      req_addr;
  logic [4:0]       req_len;
  logic [NP*CW-1:0] ram_count;

  logic             s_req_valid, s_req_dir, s_busy, s_protocol_err;
  logic [2:0]       s_req_port;
  logic [22:0]      s_req_addr;
  logic [4:0]       s_req_len;
  logic [NP*SCW-1:0] s_ram_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_burst_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .port_enable   (port_enable),
    .wr_fifo_level (wr_fifo_level),
    .rd_fifo_space (rd_fifo_space),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dir       (req_dir),
    .req_port      (req_port),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .req_done      (req_done),
    .ram_count     (ram_count),
    .busy          (busy),
    .protocol_err  (protocol_err)
  );

  mem_burst_scheduler #(.REGION_AW(6)) dut_small (
    .clk           (clk),
    .reset         (reset),
    .port_enable   (port_enable),
    .wr_fifo_level (wr_fifo_level),
    .rd_fifo_space (rd_fifo_space),
    .req_valid     (s_req_valid),
    .req_ready     (s_req_ready),
    .req_dir       (s_req_dir),
    .req_port      (s_req_port),
    .req_addr      (s_req_addr),
    .req_len       (s_req_len),
    .req_done      (s_req_done),
    .ram_count     (s_ram_count),
    .busy          (s_busy),
    .protocol_err  (s_protocol_err)
  );

  function automatic logic [CW-1:0] cnt_of(input int p);
    return ram_count[p*CW +: CW];
  endfunction

  function automatic logic [SCW-1:0] s_cnt_of(input int p);
    return s_ram_count[p*SCW +: SCW];
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    port_enable   = '0;
    wr_fifo_level = '0;
    rd_fifo_space = '0;
    req_ready     = 1'b0;
    req_done      = 1'b0;
    s_req_ready   = 1'b0;
    s_req_done    = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  // Waits (bounded) for a command, optionally stalls it, then completes it; returns in IDLE.
  task automatic run_burst(input int hold, output bit ok, output bit stable, output logic dir,
                           output logic [2:0] port, output logic [22:0] addr);
    int cnt = 0;
    ok     = 1'b0;
    stable = 1'b1;
    while (!req_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    dir  = req_dir;
    port = req_port;
    addr = req_addr;
    if (req_valid) begin
      ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (req_valid !== 1'b1 || req_dir !== dir || req_port !== port || req_addr !== addr ||
            req_len !== 5'd16) stable = 1'b0;
      end
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      req_done  = 1'b1;
      tick();
      req_done  = 1'b0;
      tick();
    end
  endtask

  task automatic s_run_burst(output bit ok, output logic dir, output logic [22:0] addr);
    int cnt = 0;
    ok = 1'b0;
    while (!s_req_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    dir  = s_req_dir;
    addr = s_req_addr;
    if (s_req_valid) begin
      ok = 1'b1;
      s_req_ready = 1'b1;
      tick();
      s_req_ready = 1'b0;
      s_req_done  = 1'b1;
      tick();
      s_req_done  = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (req_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", req_valid); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (ram_count !== '0) $display("FAIL rst_count: got %h want 0", ram_count); else n_pass++;
    n_checks++;
    if (protocol_err !== 1'b0 || req_addr !== '0 || req_len !== '0)
      $display("FAIL rst_outs: got err=%b addr=%h len=%0d want 0/0/0", protocol_err, req_addr,
               req_len);
    else n_pass++;
  endtask

  task automatic test_single_write();
    bit ok, st;
    logic d;
    logic [2:0] p;
    logic [22:0] a;
    do_reset();
    port_enable = 8'h01;
    wr_fifo_level[0 +: LW] = 12'd32;
    tick();
    n_checks++;
    if (req_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL wr_latency: got valid=%b busy=%b want 1/1", req_valid, busy);
    else n_pass++;
    n_checks++;
    if (req_dir !== 1'b0 || req_port !== 3'd0 || req_addr !== 23'h000000 || req_len !== 5'd16)
      $display("FAIL wr_cmd: got dir=%b port=%0d addr=%h len=%0d want 0/0/000000/16", req_dir,
               req_port, req_addr, req_len);
    else n_pass++;
    run_burst(0, ok, st, d, p, a);
    n_checks++;
    if (cnt_of(0) !== 21'd16 || busy !== 1'b0)
      $display("FAIL wr_count: got count=%0d busy=%b want 16/0", cnt_of(0), busy);
    else n_pass++;
    run_burst(0, ok, st, d, p, a);
    n_checks++;
    if (!ok || d !== 1'b0 || a !== 23'h000010)
      $display("FAIL wr_next_addr: got ok=%b dir=%b addr=%h want 1/0/000010", ok, d, a);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    bit ok, st;
    logic d;
    logic [2:0] p;
    logic [22:0] a;
    int cnt = 0;
    while (!req_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (req_valid !== 1'b0 || busy !== 1'b0 || ram_count !== '0)
      $display("FAIL midwait_rst: got valid=%b busy=%b count=%h want 0/0/0", req_valid, busy,
               ram_count);
    else n_pass++;
    run_burst(0, ok, st, d, p, a);
    n_checks++;
    if (!ok || d !== 1'b0 || a !== 23'h000000)
      $display("FAIL midwait_restart: got ok=%b dir=%b addr=%h want 1/0/000000", ok, d, a);
    else n_pass++;
  endtask

  task automatic test_read();
    bit ok, st;
    logic d;
    logic [2:0] p;
    logic [22:0] a;
    do_reset();
    port_enable = 8'h04;
    wr_fifo_level[2*LW +: LW] = 12'd32;
    run_burst(0, ok, st, d, p, a);
    wr_fifo_level[2*LW +: LW] = 12'd0;
    rd_fifo_space[2*LW +: LW] = 12'd2048;
    n_checks++;
    if (!ok || d !== 1'b0 || p !== 3'd2 || a !== 23'h200000)
      $display("FAIL rd_prewrite: got ok=%b dir=%b port=%0d addr=%h want 1/0/2/200000", ok, d,
               p, a);
    else n_pass++;
    run_burst(0, ok, st, d, p, a);
    n_checks++;
    if (!ok || d !== 1'b1 || p !== 3'd2 || a !== 23'h200000)
      $display("FAIL rd_cmd: got ok=%b dir=%b port=%0d addr=%h want 1/1/2/200000", ok, d, p, a);
    else n_pass++;
    n_checks++;
    if (cnt_of(2) !== 21'd0) $display("FAIL rd_count: got %0d want 0", cnt_of(2)); else n_pass++;
  endtask

  task automatic test_rr_order();
    bit ok, st;
    logic d;
    logic [2:0] p;
    logic [22:0] a;
    logic [2:0] exp_port [4] = '{3'd0, 3'd1, 3'd3, 3'd0};
    do_reset();
    port_enable = 8'b0000_1011;
    wr_fifo_level[0*LW +: LW] = 12'd32;
    wr_fifo_level[1*LW +: LW] = 12'd32;
    wr_fifo_level[3*LW +: LW] = 12'd32;
    for (int i = 0; i < 4; i++) begin
      run_burst((i == 0) ? 5 : 0, ok, st, d, p, a);
      n_checks++;
      if (!ok || d !== 1'b0 || p !== exp_port[i])
        $display("FAIL rr_grant%0d: got ok=%b dir=%b port=%0d want 1/0/%0d", i, ok, d, p,
                 exp_port[i]);
      else n_pass++;
      if (i == 0) begin
        n_checks++;
        if (st !== 1'b1) $display("FAIL rr_hold_stable: got %b want 1", st); else n_pass++;
      end
      if (i == 2) begin
        n_checks++;
        if (a !== 23'h300000) $display("FAIL rr_addr_p3: got %h want 300000", a); else n_pass++;
      end
      if (i == 3) begin
        n_checks++;
        if (a !== 23'h000010) $display("FAIL rr_addr_p0: got %h want 000010", a); else n_pass++;
      end
    end
  endtask

  task automatic test_region_full();
    bit ok;
    bit seen = 1'b0;
    logic d;
    logic [22:0] a;
    do_reset();
    port_enable = 8'h01;
    wr_fifo_level[0 +: LW] = 12'd2048;
    for (int i = 0; i < 4; i++) begin
      s_run_burst(ok, d, a);
      n_checks++;
      if (!ok || d !== 1'b0 || a !== 23'(16 * i))
        $display("FAIL full_wr%0d: got ok=%b dir=%b addr=%h want 1/0/%h", i, ok, d, a, 16 * i);
      else n_pass++;
    end
    n_checks++;
    if (s_cnt_of(0) !== 7'd64) $display("FAIL full_count: got %0d want 64", s_cnt_of(0));
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_req_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL full_blocked: got req %b want 0", seen); else n_pass++;
    rd_fifo_space[0 +: LW] = 12'd2048;
    s_run_burst(ok, d, a);
    n_checks++;
    if (!ok || d !== 1'b1 || a !== 23'h0 || s_cnt_of(0) !== 7'd48)
      $display("FAIL full_read: got ok=%b dir=%b addr=%h count=%0d want 1/1/0/48", ok, d, a,
               s_cnt_of(0));
    else n_pass++;
    s_run_burst(ok, d, a);
    n_checks++;
    if (!ok || d !== 1'b0 || a !== 23'h0 || s_cnt_of(0) !== 7'd64)
      $display("FAIL full_wrap: got ok=%b dir=%b addr=%h count=%0d want 1/0/0/64", ok, d, a,
               s_cnt_of(0));
    else n_pass++;
  endtask

  task automatic test_read_priority();
    bit ok, st;
    logic d;
    logic exp_dir;
    logic [2:0] p;
    logic [22:0] a;
`ifdef MEM_SCHED_READ_PRIORITY_EN
    exp_dir = 1'b1;
`else
    exp_dir = 1'b0;
`endif
    do_reset();
    port_enable = 8'h03;
    wr_fifo_level[0*LW +: LW] = 12'd32;
    wr_fifo_level[1*LW +: LW] = 12'd32;
    run_burst(0, ok, st, d, p, a);
    run_burst(0, ok, st, d, p, a);
    n_checks++;
    if (!ok || p !== 3'd1 || d !== 1'b0)
      $display("FAIL prio_setup: got ok=%b port=%0d dir=%b want 1/1/0", ok, p, d);
    else n_pass++;
    rd_fifo_space[0*LW +: LW] = 12'd2048;
    run_burst(0, ok, st, d, p, a);
    n_checks++;
    if (!ok || p !== 3'd0 || d !== exp_dir)
      $display("FAIL prio_pick: got ok=%b port=%0d dir=%b want 1/0/%b", ok, p, d, exp_dir);
    else n_pass++;
  endtask

  task automatic test_protocol_err();
    do_reset();
    tick();
    n_checks++;
    if (protocol_err !== 1'b0) $display("FAIL perr_clear: got %b want 0", protocol_err);
    else n_pass++;
    req_done = 1'b1;
    tick();
    req_done = 1'b0;
    n_checks++;
    if (protocol_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL perr_set: got err=%b busy=%b want 1/0", protocol_err, busy);
    else n_pass++;
    tick(3);
    n_checks++;
    if (protocol_err !== 1'b1) $display("FAIL perr_sticky: got %b want 1", protocol_err);
    else n_pass++;
  endtask

  task automatic test_flush();
    bit ok, st;
    logic d;
    logic [2:0] p;
    logic [22:0] a;
    do_reset();
    port_enable = 8'h01;
    wr_fifo_level[0 +: LW] = 12'd32;
    run_burst(0, ok, st, d, p, a);
    port_enable = 8'h00;
    tick();
    n_checks++;
    if (cnt_of(0) !== 21'd0) $display("FAIL flush_count: got %0d want 0", cnt_of(0));
    else n_pass++;
    port_enable = 8'h01;
    run_burst(0, ok, st, d, p, a);
    n_checks++;
    if (!ok || a !== 23'h000000 || cnt_of(0) !== 21'd16)
      $display("FAIL flush_restart: got ok=%b addr=%h count=%0d want 1/000000/16", ok, a,
               cnt_of(0));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_reset_mid_wait();
    test_read();
    test_rr_order();
    test_region_full();
    test_read_priority();
    test_protocol_err();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
